// File: rtl/fp_check_wire.sv
// rtl/fp_check_wire.sv - shared types and constants for the fp_unit result checker
package fp_check_wire;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] result;
        logic [4:0]  flags;
        logic        nomask;
    } fp_check_entry_type;

    typedef enum logic [1:0] {
        ERR_NONE           = 2'd0,
        ERR_MISMATCH       = 2'd1,
        ERR_UNDERFLOW      = 2'd2,
        ERR_PUSH_AFTER_END = 2'd3
    } fp_check_err_type;

    // A canonical NaN result matches any NaN-shaped expectation unless the op
    // produces integer/compare results, where the bit pattern is exact.
    function automatic logic entry_mismatch(input fp_check_entry_type entry,
                                            input logic [31:0]        calc_result,
                                            input logic [4:0]         calc_flags);
        logic [31:0] diff;
        diff = entry.result ^ calc_result;
        if (!entry.nomask && calc_result == FP_CANON_NAN) begin
            diff[21:0] = 22'd0;
            diff[31]   = 1'b0;
        end
        return (diff != 32'd0) || (entry.flags != calc_flags);
    endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// rtl/fp_check_fifo.sv - synchronous FIFO of expectation entries
module fp_check_fifo
    import fp_check_wire::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  fp_check_entry_type push_entry,
    input  logic               pop,
    output fp_check_entry_type head_entry,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count
);

    fp_check_entry_type mem_q [DEPTH];
    fp_check_entry_type mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_entry = mem_q[rd_ptr_q];
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fp_result_check.sv
// rtl/fp_result_check.sv - in-order checker comparing fp_unit results against expectations
module fp_result_check
    import fp_check_wire::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          exp_valid,
    output logic          exp_ready,
    input  logic [31:0]   exp_data1,
    input  logic [31:0]   exp_data2,
    input  logic [31:0]   exp_result,
    input  logic [4:0]    exp_flags,
    input  logic          exp_nomask,
    input  logic          res_valid,
    input  logic [31:0]   res_result,
    input  logic [4:0]    res_flags,
    input  logic          stream_end,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    err_code,
    output logic [31:0]   err_data1,
    output logic [31:0]   err_data2,
    output logic [31:0]   err_expected,
    output logic [31:0]   err_calculated,
    output logic [4:0]    err_flags_exp,
    output logic [4:0]    err_flags_calc,
    output logic [31:0]   vec_count,
    output logic [AW:0]   pending
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    logic [1:0]         state_q, state_d;
    fp_check_err_type   err_code_q, err_code_d;
    logic [31:0]        err_data1_q, err_data1_d;
    logic [31:0]        err_data2_q, err_data2_d;
    logic [31:0]        err_expected_q, err_expected_d;
    logic [31:0]        err_calculated_q, err_calculated_d;
    logic [4:0]         err_flags_exp_q, err_flags_exp_d;
    logic [4:0]         err_flags_calc_q, err_flags_calc_d;
    logic [31:0]        vec_count_q, vec_count_d;

    fp_check_entry_type push_entry;
    fp_check_entry_type head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic [AW:0]        fifo_count;
    logic               active;
    logic               push;
    logic               pop;
    logic               underflow_err;
    logic               mismatch_err;
    logic               late_push_err;

    assign push_entry = '{data1: exp_data1, data2: exp_data2, result: exp_result,
                          flags: exp_flags, nomask: exp_nomask};

    assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign exp_ready = !fifo_full && (state_q == ST_RUN);
    assign push      = exp_valid && exp_ready;

    // Occupancy is the pre-push value, so a same-cycle push never satisfies a result.
    assign underflow_err = active && res_valid && fifo_empty;
    assign pop           = active && res_valid && !fifo_empty;
    assign mismatch_err  = pop && entry_mismatch(head_entry, res_result, res_flags);
    assign late_push_err = (state_q == ST_DRAIN) && exp_valid;

    fp_check_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        state_d          = state_q;
        err_code_d       = err_code_q;
        err_data1_d      = err_data1_q;
        err_data2_d      = err_data2_q;
        err_expected_d   = err_expected_q;
        err_calculated_d = err_calculated_q;
        err_flags_exp_d  = err_flags_exp_q;
        err_flags_calc_d = err_flags_calc_q;
        vec_count_d      = vec_count_q;

        if (pop) begin
            vec_count_d = vec_count_q + 32'd1;
        end

        if (underflow_err) begin
            state_d          = ST_FAIL;
            err_code_d       = ERR_UNDERFLOW;
            err_calculated_d = res_result;
            err_flags_calc_d = res_flags;
        end else if (mismatch_err) begin
            state_d          = ST_FAIL;
            err_code_d       = ERR_MISMATCH;
            err_data1_d      = head_entry.data1;
            err_data2_d      = head_entry.data2;
            err_expected_d   = head_entry.result;
            err_flags_exp_d  = head_entry.flags;
            err_calculated_d = res_result;
            err_flags_calc_d = res_flags;
        end else if (late_push_err) begin
            state_d    = ST_FAIL;
            err_code_d = ERR_PUSH_AFTER_END;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stream_end) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !pop) begin
                        state_d = ST_PASS;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= ST_RUN;
            err_code_q       <= ERR_NONE;
            err_data1_q      <= '0;
            err_data2_q      <= '0;
            err_expected_q   <= '0;
            err_calculated_q <= '0;
            err_flags_exp_q  <= '0;
            err_flags_calc_q <= '0;
            vec_count_q      <= '0;
        end else begin
            state_q          <= state_d;
            err_code_q       <= err_code_d;
            err_data1_q      <= err_data1_d;
            err_data2_q      <= err_data2_d;
            err_expected_q   <= err_expected_d;
            err_calculated_q <= err_calculated_d;
            err_flags_exp_q  <= err_flags_exp_d;
            err_flags_calc_q <= err_flags_calc_d;
            vec_count_q      <= vec_count_d;
        end
    end

    assign busy           = active;
    assign pass           = (state_q == ST_PASS);
    assign fail           = (state_q == ST_FAIL);
    assign err_code       = err_code_q;
    assign err_data1      = err_data1_q;
    assign err_data2      = err_data2_q;
    assign err_expected   = err_expected_q;
    assign err_calculated = err_calculated_q;
    assign err_flags_exp  = err_flags_exp_q;
    assign err_flags_calc = err_flags_calc_q;
    assign vec_count      = vec_count_q;
    assign pending        = fifo_count;

endmodule

// File: tb/tb_fp_result_check.sv
// tb/tb_fp_result_check.sv - directed self-checking bench for fp_result_check
module tb_fp_result_check;

    logic        clock = 1'b0;
    logic        reset;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_data1;
    logic [31:0] exp_data2;
    logic [31:0] exp_result;
    logic [4:0]  exp_flags;
    logic        exp_nomask;
    logic        res_valid;
    logic [31:0] res_result;
    logic [4:0]  res_flags;
    logic        stream_end;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  err_code;
    logic [31:0] err_data1;
    logic [31:0] err_data2;
    logic [31:0] err_expected;
    logic [31:0] err_calculated;
    logic [4:0]  err_flags_exp;
    logic [4:0]  err_flags_calc;
    logic [31:0] vec_count;
    logic [3:0]  pending;

    int tests_run = 0;
    int tests_failed = 0;

    fp_result_check #(.DEPTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_data1      (exp_data1),
        .exp_data2      (exp_data2),
        .exp_result     (exp_result),
        .exp_flags      (exp_flags),
        .exp_nomask     (exp_nomask),
        .res_valid      (res_valid),
        .res_result     (res_result),
        .res_flags      (res_flags),
        .stream_end     (stream_end),
        .busy           (busy),
        .pass           (pass),
        .fail           (fail),
        .err_code       (err_code),
        .err_data1      (err_data1),
        .err_data2      (err_data2),
        .err_expected   (err_expected),
        .err_calculated (err_calculated),
        .err_flags_exp  (err_flags_exp),
        .err_flags_calc (err_flags_calc),
        .vec_count      (vec_count),
        .pending        (pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        exp_valid  = 1'b0;
        exp_data1  = '0;
        exp_data2  = '0;
        exp_result = '0;
        exp_flags  = '0;
        exp_nomask = 1'b0;
        res_valid  = 1'b0;
        res_result = '0;
        res_flags  = '0;
        stream_end = 1'b0;
    endtask

    // Drive one cycle of stimulus, clock it in, sample 1 time unit after the edge.
    task automatic step(input logic ev, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] r, input logic [4:0] f, input logic nm,
                        input logic rv, input logic [31:0] rr, input logic [4:0] rf,
                        input logic se);
        exp_valid  = ev;
        exp_data1  = d1;
        exp_data2  = d2;
        exp_result = r;
        exp_flags  = f;
        exp_nomask = nm;
        res_valid  = rv;
        res_result = rr;
        res_flags  = rf;
        stream_end = se;
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_ready", 32'(exp_ready), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_vec_count", vec_count, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_err_data1", err_data1, 32'd0);

        // Three matching vectors, result one cycle after each push
        step(1, 32'h1111_0000, 32'h2222_0000, 32'h3F80_0000, 5'h00, 0, 0, 0, 0, 0);
        step(1, 32'h1111_0001, 32'h2222_0001, 32'h4000_0000, 5'h00, 0, 1, 32'h3F80_0000, 5'h00, 0);
        step(1, 32'h1111_0002, 32'h2222_0002, 32'h7F80_0000, 5'h05, 0, 1, 32'h4000_0000, 5'h00, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h7F80_0000, 5'h05, 1);
        chk("t1_drain_busy", 32'(busy), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_fail", 32'(fail), 32'd0);
        chk("t1_vec_count", vec_count, 32'd3);
        chk("t1_busy", 32'(busy), 32'd0);

        // NaN masking applies only when nomask is clear
        do_reset();
        step(1, 32'hA, 32'hB, 32'h7FC1_2345, 5'h10, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h7FC0_0000, 5'h10, 0);
        chk("t2_masked_fail", 32'(fail), 32'd0);
        chk("t2_masked_count", vec_count, 32'd1);
        step(1, 32'hC, 32'hD, 32'h7FC1_2345, 5'h10, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h7FC0_0000, 5'h10, 0);
        chk("t2_nomask_fail", 32'(fail), 32'd1);
        chk("t2_err_code", 32'(err_code), 32'd1);
        chk("t2_err_expected", err_expected, 32'h7FC1_2345);
        chk("t2_err_calculated", err_calculated, 32'h7FC0_0000);
        chk("t2_err_data1", err_data1, 32'hC);

        // Flag-only mismatch
        do_reset();
        step(1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h3F80_0000, 5'h01, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h3F80_0000, 5'h00, 0);
        chk("t3_fail", 32'(fail), 32'd1);
        chk("t3_err_code", 32'(err_code), 32'd1);
        chk("t3_flags_exp", 32'(err_flags_exp), 32'h01);
        chk("t3_flags_calc", 32'(err_flags_calc), 32'h00);
        chk("t3_err_data1", err_data1, 32'h1234_5678);
        chk("t3_err_data2", err_data2, 32'h9ABC_DEF0);
        step(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 5'h1F, 0);
        chk("t3_latched_calc", err_calculated, 32'h3F80_0000);

        // Full FIFO: push refused during a same-cycle pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 32'(i), 32'(i + 100), 32'h4000_0000 + 32'(i), 5'h00, 0, 0, 0, 0, 0);
        end
        chk("t4_full_ready", 32'(exp_ready), 32'd0);
        chk("t4_full_pending", 32'(pending), 32'd8);
        step(1, 32'hFF, 32'hFF, 32'h0000_0055, 5'h00, 0, 1, 32'h4000_0000, 5'h00, 0);
        chk("t4_pushpop_pending", 32'(pending), 32'd7);
        chk("t4_pushpop_count", vec_count, 32'd1);
        chk("t4_ready_again", 32'(exp_ready), 32'd1);
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 32'h4000_0000 + 32'(i), 5'h00, (i == 7) ? 1'b1 : 1'b0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_pass", 32'(pass), 32'd1);
        chk("t4_fail", 32'(fail), 32'd0);
        chk("t4_vec_count", vec_count, 32'd8);

        // Result in the same cycle as the first push is an underflow
        do_reset();
        step(1, 32'h77, 32'h88, 32'h3F80_0000, 5'h00, 0, 1, 32'h3F80_0000, 5'h00, 0);
        chk("t5_fail", 32'(fail), 32'd1);
        chk("t5_err_code", 32'(err_code), 32'd2);
        chk("t5_err_data1", err_data1, 32'd0);
        chk("t5_err_expected", err_expected, 32'd0);

        // Reset in the middle of DRAIN discards pending entries
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 32'(i), 32'(i), 32'h3F80_0000, 5'h00, 0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_drain_busy", 32'(busy), 32'd1);
        chk("t6_drain_pending", 32'(pending), 32'd4);
        chk("t6_drain_ready", 32'(exp_ready), 32'd0);
        do_reset();
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd1);
        chk("t6_rst_fail", 32'(fail), 32'd0);
        chk("t6_rst_vec_count", vec_count, 32'd0);
        chk("t6_rst_ready", 32'(exp_ready), 32'd1);

        // Push after stream_end
        step(1, 32'h5, 32'h6, 32'h3F80_0000, 5'h00, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h99, 32'h99, 32'h4000_0000, 5'h00, 0, 0, 0, 0, 0);
        chk("t7_fail", 32'(fail), 32'd1);
        chk("t7_err_code", 32'(err_code), 32'd3);
        chk("t7_err_data1", err_data1, 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fp_result_check.md
Name: fp_result_check

Overview:
- Synthesizable result checker that sits directly downstream of fp_unit.
- Captures the expected result, expected flags and op class for every vector issued to fp_unit, and buffers them in order.
- Compares each fp_unit result against the oldest buffered expectation, applying the quiet-NaN masking rule.
- Latches the first mismatch for reporting and counts vectors until the stream drains.

Parameters:
- DEPTH, 8, expectation FIFO entries; power of two, 2..64.
- AW, $clog2(DEPTH), FIFO pointer width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- exp_valid  in  1  expectation push (same cycle the vector enables fp_unit)
- exp_ready  out  1  FIFO can accept an entry
- exp_data1  in  32  operand A, kept for the failure report
- exp_data2  in  32  operand B, kept for the failure report
- exp_result  in  32  reference result
- exp_flags  in  5  reference fflags (NV,DZ,OF,UF,NX)
- exp_nomask  in  1  op is fcmp or fcvt_f2i; disables NaN masking
- res_valid  in  1  fp_unit result strobe
- res_result  in  32  calculated result
- res_flags  in  5  calculated flags
- stream_end  in  1  pulse: no further pushes follow
- busy  out  1  state RUN or DRAIN
- pass  out  1  sticky, stream drained with no error
- fail  out  1  sticky, mismatch or protocol error
- err_code  out  2  0 none, 1 mismatch, 2 underflow, 3 push after end
- err_data1, err_data2, err_expected, err_calculated  out  32 each  captured at first failure
- err_flags_exp, err_flags_calc  out  5 each  captured at first failure
- vec_count  out  32  results compared
- pending  out  AW+1  FIFO occupancy

Behaviour:
- Reset (reset==0 at posedge):
  - State RUN; FIFO empty.
  - All err_* outputs 0; vec_count 0.
  - pass and fail 0; exp_ready 1.
  - Reset mid-stream discards all entries.
- FSM states RUN, DRAIN, PASS, FAIL:
  - RUN -> DRAIN on stream_end.
  - DRAIN -> PASS when pending==0 and no pop is in progress.
  - Any state except PASS -> FAIL on the first error.
  - PASS and FAIL are absorbing until reset. busy=0 in both.
- Push:
  - Entry written on exp_valid & exp_ready.
  - exp_ready = (pending != DEPTH) and state == RUN.
  - While full, exp_ready=0 even if a pop occurs the same cycle.
- Pop:
  - Every res_valid in RUN or DRAIN pops the head combinationally and compares.
  - vec_count increments by one per pop.
- Simultaneous push and pop: pending is unchanged and both pointers advance.
- Same-cycle push on an empty FIFO: the pushed entry is not visible to that cycle's res_valid. fp_unit latency is >=1, so this case is an underflow error.
- Pointers: AW-bit, wrap modulo DEPTH. pending is AW+1 bits.
- Comparison:
  - diff = exp_result ^ res_result.
  - If exp_nomask==0 and res_result==32'h7FC00000, clear diff[21:0] and diff[31].
  - mismatch = (diff != 0) | (exp_flags != res_flags).
- Errors (first one latched, later errors ignored):
  - mismatch -> err_code=1.
  - res_valid with pending==0 -> err_code=2.
  - exp_valid in DRAIN -> err_code=3.
  - On an error, the err_* registers load in that cycle and are valid the next cycle along with fail.
  - For err_code 2 and 3, the entry-derived fields (err_data1, err_data2, err_expected, err_flags_exp) hold 0.
- In PASS or FAIL, pushes and res_valid are ignored.

Decomposition:
- Shared package fp_check_wire, holding:
  - typedef fp_check_entry_type (data1, data2, result, flags, nomask)
  - typedef fp_check_err_type enum
  - constant FP_CANON_NAN = 32'h7FC00000
- One sub-module, fp_check_fifo: a parameterised synchronous FIFO of fp_check_entry_type with push, pop, full, empty and count.
- FSM, compare and capture logic live in fp_result_check.

Test Plan:
- Push 3 entries (3F800000 flags 00, 40000000 flags 00, 7F800000 flags 05). Return identical results one cycle later each, then stream_end -> pass=1, vec_count=3, fail=0.
- Entry result=7FC12345, nomask=0; calculated 7FC00000 -> no error. Same pair with nomask=1 -> fail, err_code=1, err_expected=7FC12345, err_calculated=7FC00000.
- Expected 3F800000 flags 01, calculated 3F800000 flags 00 -> fail next cycle, err_flags_exp=01, err_flags_calc=00, err_data1 = that vector's A.
- DEPTH=8: push 8 with no results -> exp_ready=0, pending=8. Push+pop in the same cycle while full -> push refused, pending=7. Drain 7 matching results -> pass after stream_end.
- res_valid with an empty FIFO (including the same cycle as the first push) -> fail, err_code=2.
- After stream_end, exp_valid -> fail, err_code=3. Assert reset mid-DRAIN with 4 pending -> pending=0, state RUN, fail=0, vec_count=0.
